// File: rtl/layer2_mac_neuron.sv
// ============================================================================
// Module      : layer2_mac_neuron
// Description : Second-layer neuron fed by the 25-neuron first layer. Takes a
//               whole activation vector in one handshake, accumulates the
//               weighted sum with one multiply-accumulate per cycle, then
//               applies ReLU, an arithmetic right shift and saturation to
//               8 bits, and offers the result on a valid/ready output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   in_valid   in   1       in_act carries a complete vector
//   in_ready   out  1       ready to accept a vector (IDLE only)
//   in_act     in   N*8     unsigned activations, act[k] = in_act[8k+7:8k]
//   w_wr_en    in   1       weight write strobe (honoured in IDLE only)
//   w_wr_addr  in   IDX_W   weight index 0..N-1 (larger indices ignored)
//   w_wr_data  in   8       signed weight
//   bias       in   16      signed initial accumulator (LAYER2_BIAS_EN only)
//   out_valid  out  1       out_data valid
//   out_ready  in   1       consumer takes out_data
//   out_data   out  8       unsigned result 0..255
// Configuration macro
//   LAYER2_BIAS_EN : adds the bias port; the bias is sampled on the accept
//                    edge and loaded as the initial accumulator value.
// ============================================================================
`default_nettype none

module layer2_mac_neuron #(
  parameter int N     = 25,
  parameter int ACC_W = 22,
  parameter int SHIFT = 4,
  parameter int IDX_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*8-1:0]     in_act,
  input  logic               w_wr_en,
  input  logic [IDX_W-1:0]   w_wr_addr,
  input  logic [7:0]         w_wr_data,
`ifdef LAYER2_BIAS_EN
  input  logic signed [15:0] bias,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [7:0]               out_data_q, out_data_d;
  logic [7:0]               act_q [N];
  logic signed [7:0]        w_q   [N];

  logic                     accept;
  logic                     w_we;
  logic signed [ACC_W-1:0]  acc_init;
  logic signed [16:0]       prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shr;
  logic [7:0]               result;

`ifdef LAYER2_BIAS_EN
  assign acc_init = {{(ACC_W-16){bias[15]}}, bias};
`else
  assign acc_init = '0;
`endif

  // Activation is zero-extended to 9 bits so the product is a signed 17-bit
  // value covering 255 * (-128..127).
  assign prod    = $signed({1'b0, act_q[idx_q]}) * w_q[idx_q];
  assign acc_sum = acc_q + {{(ACC_W-17){prod[16]}}, prod};

  // ReLU, shift, saturate on the sum that includes the final term.
  assign acc_shr = acc_sum >>> SHIFT;
  always_comb begin
    result = acc_shr[7:0];
    if (acc_sum[ACC_W-1]) begin
      result = 8'd0;
    end else if (|acc_shr[ACC_W-1:8]) begin
      result = 8'hFF;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    accept     = 1'b0;
    w_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_we = w_wr_en && (w_wr_addr <= LAST_IDX);
        if (in_valid) begin
          accept  = 1'b1;
          acc_d   = acc_init;
          idx_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d      = '0;
          out_data_d = result;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        // in_valid is deliberately not looked at here: a retiring result and
        // a new vector never share a cycle.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      for (int k = 0; k < N; k++) begin
        w_q[k]   <= '0;
        act_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      // A write on the accept edge lands before the first MAC reads it.
      if (w_we) begin
        w_q[w_wr_addr] <= w_wr_data;
      end
      if (accept) begin
        for (int k = 0; k < N; k++) begin
          act_q[k] <= in_act[8*k +: 8];
        end
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;

endmodule

`default_nettype wire
